// File: rtl/pov_pkg.sv
`default_nettype none
// ============================================================================
// Module   : pov_pkg
// Brief    : Shared constants and types for the POV frame-RAM sequencer.
// Revision : 1.0
// ============================================================================
package pov_pkg;

    localparam int POV_AWIDTH = 8;
    localparam int POV_DWIDTH = 16;
    localparam int POV_WORDS  = 256;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2
    } state_t;

    // One stage of the column-read pipe: vld marks a tick, rd says the RAM
    // was actually read (otherwise the column is blanked to zero).
    typedef struct packed {
        logic vld;
        logic rd;
    } colpipe_t;

endpackage
`default_nettype wire

// File: rtl/sync_edge.sv
`default_nettype none
// ============================================================================
// Module   : sync_edge
// Brief    : Two-flop synchronizer with registered rising-edge pulse output.
// Revision : 1.0
// ============================================================================
module sync_edge (
    input  logic clk,
    input  logic rst_n,
    input  logic i_async,
    output logic o_pulse
);

    logic r_meta;
    logic r_sync;
    logic r_prev;
    logic r_pulse;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_meta  <= 1'b0;
            r_sync  <= 1'b0;
            r_prev  <= 1'b0;
            r_pulse <= 1'b0;
        end else begin
            r_meta  <= i_async;
            r_sync  <= r_meta;
            r_prev  <= r_sync;
            r_pulse <= r_sync & ~r_prev;
        end
    end

    assign o_pulse = r_pulse;

endmodule
`default_nettype wire

// File: rtl/pov_ram_sched.sv
`default_nettype none
// ============================================================================
// Module   : pov_ram_sched
// Brief    : Frame-RAM owner: ROM->RAM frame copy, then hall-indexed column reads.
// Revision : 1.0
// ============================================================================
module pov_ram_sched
    import pov_pkg::*;
#(
    parameter int DWIDTH = POV_DWIDTH,
    parameter int AWIDTH = POV_AWIDTH,
    parameter int WORDS  = POV_WORDS
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start_load,
    input  logic              hall,
    input  logic              col_tick,
    output logic [AWIDTH-1:0] rom_addr,
    input  logic [DWIDTH-1:0] rom_data,
    output logic [AWIDTH-1:0] direccionram,
    output logic              wram,
    output logic [DWIDTH-1:0] datorom,
    input  logic [DWIDTH-1:0] datoram,
    output logic [DWIDTH-1:0] led_data,
    output logic              busy,
    output logic              load_done
);

    localparam int unsigned        c_words_u    = WORDS;
    localparam int unsigned        c_last_u     = WORDS - 1;
    localparam logic [AWIDTH:0]    c_cnt_end    = c_words_u[AWIDTH:0];
    localparam logic [AWIDTH:0]    c_cnt_lastrd = c_last_u[AWIDTH:0];
    localparam logic [AWIDTH-1:0]  c_col_last   = c_last_u[AWIDTH-1:0];

    state_t             r_state;
    logic [AWIDTH:0]    r_cnt;
    logic [AWIDTH-1:0]  r_rom_addr;
    logic [AWIDTH-1:0]  r_addr;
    logic               r_wram;
    logic [DWIDTH-1:0]  r_led;
    logic               r_busy;
    logic               r_done;
    logic [AWIDTH-1:0]  r_col;
    logic               r_blank;
    colpipe_t           r_p1;
    colpipe_t           r_p2;

    logic               w_hall_pulse;
    logic               w_enter_load;
    logic [AWIDTH:0]    w_cnt_nxt;
    logic [AWIDTH-1:0]  w_col_cur;
    logic               w_blank_cur;

    sync_edge u_hall_sync (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_async (hall),
        .o_pulse (w_hall_pulse)
    );

    // Hall takes priority over a same-cycle column tick.
    always_comb begin
        w_col_cur   = r_col;
        w_blank_cur = r_blank;
        if (w_hall_pulse) begin
            w_col_cur   = '0;
            w_blank_cur = 1'b0;
        end
    end

    assign w_enter_load = start_load && (r_state != LOAD);
    assign w_cnt_nxt    = r_cnt + 1'b1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_cnt      <= '0;
            r_rom_addr <= '0;
            r_addr     <= '0;
            r_wram     <= 1'b1;
            r_led      <= '0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_col      <= '0;
            r_blank    <= 1'b1;
            r_p1       <= '0;
            r_p2       <= '0;
        end else begin
            r_done <= 1'b0;
            r_wram <= 1'b1;
            r_p1   <= '0;
            r_p2   <= r_p1;

            if (w_enter_load) begin
                // Fresh copy: blank the display and drop any in-flight read.
                r_state    <= LOAD;
                r_cnt      <= '0;
                r_rom_addr <= '0;
                r_busy     <= 1'b1;
                r_blank    <= 1'b1;
                r_led      <= '0;
                r_p2       <= '0;
            end else begin
                case (r_state)
                    LOAD: begin
                        // Write address trails the ROM address by one cycle.
                        if (r_cnt < c_cnt_lastrd) begin
                            r_rom_addr <= w_cnt_nxt[AWIDTH-1:0];
                        end
                        if (r_cnt == c_cnt_end) begin
                            r_state <= RUN;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                        end else begin
                            r_addr <= r_cnt[AWIDTH-1:0];
                            r_wram <= 1'b0;
                        end
                        r_cnt <= w_cnt_nxt;
                    end

                    RUN: begin
                        r_col   <= w_col_cur;
                        r_blank <= w_blank_cur;
                        if (col_tick) begin
                            r_p1 <= '{vld: 1'b1, rd: !w_blank_cur};
                            if (!w_blank_cur) begin
                                r_addr <= w_col_cur;
                                r_col  <= w_col_cur + 1'b1;
                                if (w_col_cur == c_col_last) begin
                                    r_blank <= 1'b1;
                                end
                            end
                        end
                        if (r_p2.vld) begin
                            r_led <= r_p2.rd ? datoram : '0;
                        end
                    end

                    default: begin
                        r_state <= IDLE;
                    end
                endcase
            end
        end
    end

    assign rom_addr     = r_rom_addr;
    assign direccionram = r_addr;
    assign wram         = r_wram;
    assign datorom      = r_wram ? '0 : rom_data;
    assign led_data     = r_led;
    assign busy         = r_busy;
    assign load_done    = r_done;

endmodule
`default_nettype wire

// File: tb/tb_pov_ram_sched.sv
`default_nettype none
// ============================================================================
// Module   : tb_pov_ram_sched
// Brief    : Directed self-checking bench with ROM and frame-RAM models.
// Revision : 1.0
// ============================================================================
module tb_pov_ram_sched;

    localparam int DW = 16;
    localparam int AW = 8;
    localparam int NW = 256;

    localparam logic [DW-1:0] KEY_A = 16'hA5A5;
    localparam logic [DW-1:0] KEY_B = 16'h5A5A;
    localparam logic [DW-1:0] KEY_C = 16'h0F0F;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start_load;
    logic          hall;
    logic          col_tick;
    logic [AW-1:0] rom_addr;
    logic [DW-1:0] rom_data;
    logic [AW-1:0] direccionram;
    logic          wram;
    logic [DW-1:0] datorom;
    logic [DW-1:0] datoram;
    logic [DW-1:0] led_data;
    logic          busy;
    logic          load_done;

    logic [DW-1:0] rom_mem [NW];
    logic [DW-1:0] ram_mem [NW] = '{default: 16'hDEAD};

    int n_vec = 0;
    int n_err = 0;
    int wr_total = 0;

    always #5 clk = ~clk;

    pov_ram_sched #(.DWIDTH(DW), .AWIDTH(AW), .WORDS(NW)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start_load   (start_load),
        .hall         (hall),
        .col_tick     (col_tick),
        .rom_addr     (rom_addr),
        .rom_data     (rom_data),
        .direccionram (direccionram),
        .wram         (wram),
        .datorom      (datorom),
        .datoram      (datoram),
        .led_data     (led_data),
        .busy         (busy),
        .load_done    (load_done)
    );

    always @(posedge clk) rom_data <= rom_mem[rom_addr];

    always @(posedge clk) begin
        if (wram === 1'b0) begin
            ram_mem[direccionram] <= datorom;
            wr_total <= wr_total + 1;
        end else begin
            datoram <= ram_mem[direccionram];
        end
    end

    function automatic logic [DW-1:0] pat(input int i, input logic [DW-1:0] key);
        logic [DW-1:0] v;
        v = i[DW-1:0];
        return v ^ key;
    endfunction

    task automatic check_vec(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic set_rom(input logic [DW-1:0] key);
        for (int i = 0; i < NW; i++) rom_mem[i] = pat(i, key);
    endtask

    task automatic ram_image(input string tag, input int lo, input int hi, input logic [DW-1:0] key);
        int bad;
        bad = 0;
        for (int i = lo; i <= hi; i++) if (ram_mem[i] !== pat(i, key)) bad++;
        check_vec(tag, bad, 0);
    endtask

    // Called at the negedge where start_load has just been raised.
    task automatic run_load(input string tag, input logic [DW-1:0] key);
        int busy_n, wr_n, done_n, done_idx, done_busy, seq_bad, led_bad;
        busy_n = 0; wr_n = 0; done_n = 0; done_idx = -1; done_busy = 1; seq_bad = 0; led_bad = 0;
        @(negedge clk);
        start_load = 1'b0;
        for (int j = 0; j < 270; j++) begin
            if (j > 0) @(negedge clk);
            if (busy === 1'b1) begin
                busy_n++;
                if (led_data !== '0) led_bad++;
            end
            if (wram === 1'b0) begin
                if (direccionram !== wr_n[AW-1:0] || datorom !== pat(wr_n, key) || j != wr_n + 1)
                    seq_bad++;
                wr_n++;
            end
            if (load_done === 1'b1) begin
                done_n++;
                done_idx = j;
                done_busy = busy;
            end
        end
        check_vec({tag, "_busy_cycles"}, busy_n, 257);
        check_vec({tag, "_writes"}, wr_n, 256);
        check_vec({tag, "_write_seq"}, seq_bad, 0);
        check_vec({tag, "_done_pulses"}, done_n, 1);
        check_vec({tag, "_done_cycle"}, done_idx, 257);
        check_vec({tag, "_done_in_run"}, done_busy, 0);
        check_vec({tag, "_led_blank"}, led_bad, 0);
        ram_image({tag, "_ram"}, 0, NW - 1, key);
    endtask

    // Returns at the negedge just after the pulse reaches the FSM.
    task automatic hall_rise(input logic with_tick);
        hall = 1'b1;
        repeat (3) @(negedge clk);
        col_tick = with_tick;
        @(negedge clk);
        col_tick = 1'b0;
        hall = 1'b0;
    endtask

    task automatic tick_check(input string tag, input logic [DW-1:0] prev_exp, input logic [DW-1:0] exp);
        col_tick = 1'b1;
        @(negedge clk);
        col_tick = 1'b0;
        @(negedge clk);
        check_vec({tag, "_early"}, led_data, prev_exp);
        @(negedge clk);
        check_vec(tag, led_data, exp);
    endtask

    task automatic fast_ticks(input string tag, input int n, input int first_col, input logic [DW-1:0] key);
        int bad;
        bad = 0;
        for (int c = 0; c <= n + 1; c++) begin
            col_tick = (c < n);
            @(negedge clk);
            if (c >= 2 && led_data !== pat(first_col + c - 2, key)) bad++;
        end
        col_tick = 1'b0;
        check_vec(tag, bad, 0);
    endtask

    initial begin
        int found, w0;
        rst_n = 1'b0; start_load = 1'b0; hall = 1'b0; col_tick = 1'b0;
        set_rom(KEY_A);
        repeat (2) @(negedge clk);
        check_vec("rst_wram", wram, 1);
        check_vec("rst_addr", direccionram, 0);
        check_vec("rst_rom_addr", rom_addr, 0);
        check_vec("rst_datorom", datorom, 0);
        check_vec("rst_led", led_data, 0);
        check_vec("rst_busy", busy, 0);
        check_vec("rst_done", load_done, 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        start_load = 1'b1;
        run_load("load1", KEY_A);
        check_vec("ram0", ram_mem[0], 16'hA5A5);
        check_vec("ram255", ram_mem[255], 16'hA55A);

        tick_check("blank_before_hall", 16'h0000, 16'h0000);

        hall_rise(1'b0);
        tick_check("col0", 16'h0000, 16'hA5A5);
        tick_check("col1", 16'hA5A5, 16'hA5A4);
        tick_check("col2", 16'hA5A4, 16'hA5A7);

        hall_rise(1'b0);
        fast_ticks("stream_0_254", 255, 0, KEY_A);
        tick_check("col255", 16'hA55B, 16'hA55A);
        tick_check("past_end", 16'hA55A, 16'h0000);
        hall_rise(1'b0);
        tick_check("rehall_col0", 16'h0000, 16'hA5A5);

        fast_ticks("stream_1_99", 99, 1, KEY_A);
        hall_rise(1'b1);
        @(negedge clk);
        check_vec("coinc_early", led_data, pat(99, KEY_A));
        @(negedge clk);
        check_vec("coinc_col0", led_data, 16'hA5A5);
        tick_check("coinc_next", 16'hA5A5, 16'hA5A4);

        fast_ticks("stream_2_49", 48, 2, KEY_A);
        set_rom(KEY_B);
        col_tick = 1'b1;
        @(negedge clk);
        col_tick = 1'b0;
        start_load = 1'b1;
        run_load("reload", KEY_B);
        hall_rise(1'b0);
        tick_check("reload_col0", 16'h0000, 16'h5A5A);

        set_rom(KEY_C);
        start_load = 1'b1;
        @(negedge clk);
        start_load = 1'b0;
        found = 0;
        for (int k = 0; k < 40 && found == 0; k++) begin
            @(negedge clk);
            if (wram === 1'b0 && direccionram === 8'd10) found = 1;
        end
        check_vec("reach_word10", found, 1);
        w0 = wr_total;
        rst_n = 1'b0;
        #1;
        check_vec("arst_wram", wram, 1);
        check_vec("arst_addr", direccionram, 0);
        check_vec("arst_rom_addr", rom_addr, 0);
        check_vec("arst_datorom", datorom, 0);
        check_vec("arst_led", led_data, 0);
        check_vec("arst_busy", busy, 0);
        check_vec("arst_done", load_done, 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        hall_rise(1'b1);
        repeat (3) @(negedge clk);
        check_vec("idle_led", led_data, 0);
        check_vec("idle_busy", busy, 0);
        check_vec("no_writes_after_rst", wr_total - w0, 0);
        ram_image("partial_0_9", 0, 9, KEY_C);
        ram_image("kept_10_255", 10, NW - 1, KEY_B);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
